// File: rtl/ks10_bus_arbiter_if.sv
// ks10_bus_arbiter_if
//   Bundles the requester-side and backplane-side signals of the KS10 bus
//   arbiter so that one handle carries the whole bus.
//   Requester side : reqREQ/reqADDR/reqDATA in, arbGNT/arbACK/arbNXM/
//                    arbDATA/arbBUSY out (one 36-bit lane per requester).
//   Backplane side : busREQO/busADDRO/busDATAO out, busACKI/busDATAI in.
//   Modports: master = the arbiter's view, slave = the environment's view
//   (requesters plus backplane slave).
interface ks10_bus_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    reqREQ;
    logic [NUM_REQ*36-1:0] reqADDR;
    logic [NUM_REQ*36-1:0] reqDATA;
    logic [NUM_REQ-1:0]    arbGNT;
    logic [NUM_REQ-1:0]    arbACK;
    logic [NUM_REQ-1:0]    arbNXM;
    logic [35:0]           arbDATA;
    logic                  arbBUSY;
    logic                  busREQO;
    logic [35:0]           busADDRO;
    logic [35:0]           busDATAO;
    logic                  busACKI;
    logic [35:0]           busDATAI;

    modport master (
        input  reqREQ, reqADDR, reqDATA, busACKI, busDATAI,
        output arbGNT, arbACK, arbNXM, arbDATA, arbBUSY,
               busREQO, busADDRO, busDATAO
    );

    modport slave (
        output reqREQ, reqADDR, reqDATA, busACKI, busDATAI,
        input  arbGNT, arbACK, arbNXM, arbDATA, arbBUSY,
               busREQO, busADDRO, busDATAO
    );
endinterface

// File: rtl/ks10_bus_arbiter.sv
// ks10_bus_arbiter
//   Grants the single KS10 backplane bus to one of NUM_REQ masters
//   (0 = CPU, 1 = console, 2.. = UBA DMA), drives the winner's address and
//   data onto the backplane, then waits for busACKI or a TIMEOUT-cycle
//   watchdog and returns an arbACK or arbNXM pulse to the winner.
//   Ports:
//     clk  - single clock
//     rst  - synchronous active-high reset; aborts any transfer silently
//     bus  - ks10_bus_arbiter_if.master (requester and backplane signals)
//   Build option:
//     KS10_ARB_ROUND_ROBIN_EN - round-robin winner selection starting at a
//     pointer that moves past each winner; when undefined the lowest index
//     always wins and the pointer does not exist.
//   Cycle shape: IDLE -> REQ (1) -> WAIT (0..TIMEOUT) -> HOLD (1) -> IDLE.
//   HOLD drops the grant for one cycle so masters never hand over the bus
//   without a dead cycle.
module ks10_bus_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    ks10_bus_arbiter_if.master       bus
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t               state_q;
    logic [IW-1:0]        win_q;
    logic [CW-1:0]        cnt_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic [NUM_REQ-1:0]   nxm_q;
    logic [35:0]          rdata_q;
    logic                 busy_q;
    logic                 breq_q;
    logic [35:0]          addr_q;
    logic [35:0]          wdata_q;

    logic                 win_vld_d;
    logic [IW-1:0]        win_d;
    logic [NUM_REQ-1:0]   win_oh;

    assign win_oh = NUM_REQ'(1) << win_q;

`ifdef KS10_ARB_ROUND_ROBIN_EN
    logic [IW-1:0] ptr_q;

    // Scan downward from the farthest slot so the requester nearest the
    // pointer (in wrap order) is the last, and therefore winning, assignment.
    always_comb begin
        int idx;
        idx       = 0;
        win_vld_d = 1'b0;
        win_d     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (bus.reqREQ[idx]) begin
                win_vld_d = 1'b1;
                win_d     = IW'(idx);
            end
        end
    end
`else
    // Fixed priority: lowest index wins, so the CPU always wins ties.
    always_comb begin
        win_vld_d = 1'b0;
        win_d     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.reqREQ[i]) begin
                win_vld_d = 1'b1;
                win_d     = IW'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            nxm_q   <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            breq_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef KS10_ARB_ROUND_ROBIN_EN
            ptr_q   <= '0;
`endif
        end else begin
            // Completion pulses and the backplane request last one cycle.
            ack_q  <= '0;
            nxm_q  <= '0;
            breq_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (win_vld_d) begin
                        win_q   <= win_d;
                        addr_q  <= bus.reqADDR[int'(win_d)*36 +: 36];
                        wdata_q <= bus.reqDATA[int'(win_d)*36 +: 36];
                        gnt_q   <= NUM_REQ'(1) << win_d;
                        breq_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_REQ;
`ifdef KS10_ARB_ROUND_ROBIN_EN
                        ptr_q   <= (win_d == IW'(NUM_REQ - 1)) ? '0 : win_d + 1'b1;
`endif
                    end
                end
                S_REQ: begin
                    cnt_q <= '0;
                    // A zero-wait slave completes straight out of REQ.
                    if (bus.busACKI) begin
                        rdata_q <= bus.busDATAI;
                        ack_q   <= win_oh;
                        gnt_q   <= '0;
                        state_q <= S_HOLD;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // ACK is tested first so a late ACK beats the watchdog.
                    if (bus.busACKI) begin
                        rdata_q <= bus.busDATAI;
                        ack_q   <= win_oh;
                        gnt_q   <= '0;
                        state_q <= S_HOLD;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        rdata_q <= '0;
                        nxm_q   <= win_oh;
                        gnt_q   <= '0;
                        state_q <= S_HOLD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_HOLD: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.arbGNT   = gnt_q;
    assign bus.arbACK   = ack_q;
    assign bus.arbNXM   = nxm_q;
    assign bus.arbDATA  = rdata_q;
    assign bus.arbBUSY  = busy_q;
    assign bus.busREQO  = breq_q;
    assign bus.busADDRO = addr_q;
    assign bus.busDATAO = wdata_q;

endmodule

// File: tb/tb_ks10_bus_arbiter.sv
// tb_ks10_bus_arbiter
//   Drives requesters and a programmable-latency backplane slave, and
//   checks each transfer against a transaction-level model: winner chosen
//   from the request set by priority (or round robin), completion at
//   latency+1 cycles after busREQO, or TIMEOUT+1 when the slave never
//   answers.
module tb_ks10_bus_arbiter;

    localparam int NR = 4;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ks10_bus_arbiter_if #(.NUM_REQ(NR)) bif();

    ks10_bus_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int vectors    = 0;
    int miscompares = 0;
    int mptr       = 0;

    logic [35:0] addr_tab [NR];
    logic [35:0] data_tab [NR];

    // Observations of one transfer, filled in by serve().
    int            o_wait, o_glen, o_blen, o_pk;
    logic [NR-1:0] o_g, o_ack, o_nxm;
    logic [35:0]   o_a, o_wd, o_dv;

    function automatic int pick(input logic [NR-1:0] r, input int ptr);
        int w;
        w = -1;
`ifdef KS10_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < NR; k++)
            if (w < 0 && r[(ptr + k) % NR]) w = (ptr + k) % NR;
`else
        for (int i = 0; i < NR; i++)
            if (w < 0 && r[i]) w = i;
`endif
        return w;
    endfunction

    function automatic logic [NR-1:0] onehot(input int w);
        logic [NR-1:0] v;
        v = '0;
        if (w >= 0) v[w] = 1'b1;
        return v;
    endfunction

    function automatic int exp_pk(input int lat);
        return (lat <= TO) ? lat + 1 : TO + 1;
    endfunction

    task automatic load_tables();
        for (int i = 0; i < NR; i++) begin
            bif.reqADDR[i*36 +: 36] = addr_tab[i];
            bif.reqDATA[i*36 +: 36] = data_tab[i];
        end
    endtask

    task automatic note_grant(input int w);
`ifdef KS10_ARB_ROUND_ROBIN_EN
        mptr = (w + 1) % NR;
`else
        mptr = w;
`endif
    endtask

    // Acts as the backplane slave for one transfer: waits (bounded) for
    // busREQO, raises busACKI lat cycles later (never if lat > TO), and
    // returns at the negedge where the completion pulse is seen.
    task automatic serve(input int lat, input logic [35:0] rd,
                         input int chg_k, input logic [NR-1:0] chg_req);
        o_wait = -1; o_glen = 0; o_blen = 0; o_pk = -1;
        o_g = '0; o_ack = '0; o_nxm = '0; o_a = '0; o_wd = '0; o_dv = '0;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (bif.busREQO) begin
                o_wait = w + 1;
                o_g = bif.arbGNT; o_a = bif.busADDRO; o_wd = bif.busDATAO;
                o_glen = 1; o_blen = 1;
                break;
            end
        end
        if (o_wait < 0) return;
        bif.busACKI  = (lat == 0);
        bif.busDATAI = rd;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == chg_k) bif.reqREQ = chg_req;
            if (bif.arbGNT == o_g) o_glen++;
            if (bif.busREQO) o_blen++;
            if ((bif.arbACK | bif.arbNXM) != '0) begin
                o_pk = k; o_ack = bif.arbACK; o_nxm = bif.arbNXM; o_dv = bif.arbDATA;
                break;
            end
            bif.busACKI = (k == lat);
        end
        bif.busACKI = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bif.reqREQ = '0; bif.busACKI = 1'b0; bif.busDATAI = '0;
        for (int i = 0; i < NR; i++) begin
            addr_tab[i] = {$urandom, $urandom} & 36'hF_FFFF_FFFF;
            data_tab[i] = {$urandom, $urandom} & 36'hF_FFFF_FFFF;
        end
        load_tables();
        repeat (3) @(negedge clk);
        vectors++;
        if ({bif.arbGNT, bif.arbACK, bif.arbNXM, bif.arbDATA, bif.arbBUSY,
             bif.busREQO, bif.busADDRO, bif.busDATAO} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got gnt=%b ack=%b nxm=%b busy=%b breq=%b want all 0",
                     bif.arbGNT, bif.arbACK, bif.arbNXM, bif.arbBUSY, bif.busREQO);
        end
        rst = 1'b0;
        mptr = 0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        logic [35:0] rd;
        rd = 36'o123456654321;
        addr_tab[0] = 36'o010000001000;
        load_tables();
        bif.reqREQ = 4'b0001;
        serve(3, rd, -1, '0);
        bif.reqREQ = '0;
        note_grant(0);
        vectors++;
        if (o_wait !== 1) begin miscompares++; $display("FAIL single_latency: got %0d want 1", o_wait); end
        vectors++;
        if (o_a !== 36'o010000001000) begin miscompares++; $display("FAIL single_addr: got %o want %o", o_a, 36'o010000001000); end
        vectors++;
        if (o_g !== 4'b0001 || o_glen !== 4 || o_blen !== 1) begin
            miscompares++; $display("FAIL single_gnt: got gnt=%b len=%0d breq=%0d want 0001/4/1", o_g, o_glen, o_blen);
        end
        vectors++;
        if (o_pk !== 4 || o_ack !== 4'b0001 || o_nxm !== 4'b0000) begin
            miscompares++; $display("FAIL single_ack: got at=%0d ack=%b nxm=%b want 4/0001/0000", o_pk, o_ack, o_nxm);
        end
        vectors++;
        if (o_dv !== rd) begin miscompares++; $display("FAIL single_data: got %o want %o", o_dv, rd); end
        repeat (3) @(negedge clk);
        vectors++;
        if (bif.arbDATA !== rd || bif.arbBUSY !== 1'b0 || bif.arbGNT !== '0) begin
            miscompares++; $display("FAIL single_idle_hold: got data=%o busy=%b gnt=%b want %o/0/0000",
                                    bif.arbDATA, bif.arbBUSY, bif.arbGNT, rd);
        end
    endtask

    task automatic test_zero_wait();
        logic [35:0] rd;
        rd = 36'o777000111222;
        bif.reqREQ = 4'b0010;
        serve(0, rd, -1, '0);
        bif.reqREQ = '0;
        note_grant(1);
        vectors++;
        if (o_g !== 4'b0010 || o_glen !== 1 || o_a !== addr_tab[1] || o_wd !== data_tab[1]) begin
            miscompares++; $display("FAIL zero_wait_req: got gnt=%b len=%0d addr=%o want 0010/1/%o", o_g, o_glen, o_a, addr_tab[1]);
        end
        vectors++;
        if (o_pk !== 1 || o_ack !== 4'b0010 || o_nxm !== '0 || o_dv !== rd) begin
            miscompares++; $display("FAIL zero_wait_ack: got at=%0d ack=%b nxm=%b data=%o want 1/0010/0000/%o",
                                    o_pk, o_ack, o_nxm, o_dv, rd);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        bif.reqREQ = 4'b0100;
        serve(1000, 36'o555555555555, -1, '0);
        bif.reqREQ = '0;
        note_grant(2);
        vectors++;
        if (o_pk !== TO + 1 || o_glen !== TO + 1) begin
            miscompares++; $display("FAIL timeout_cycles: got at=%0d gntlen=%0d want %0d/%0d", o_pk, o_glen, TO + 1, TO + 1);
        end
        vectors++;
        if (o_nxm !== 4'b0100 || o_ack !== '0 || o_dv !== '0) begin
            miscompares++; $display("FAIL timeout_nxm: got nxm=%b ack=%b data=%o want 0100/0000/0", o_nxm, o_ack, o_dv);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_contention();
        int w;
        bif.reqREQ = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            serve(0, 36'(n + 1), -1, '0);
            w = pick(4'b1111, mptr);
            note_grant(w);
            vectors++;
            if (o_g !== onehot(w) || o_ack !== onehot(w) || o_pk !== 1 || o_wait !== ((n == 0) ? 1 : 2)) begin
                miscompares++; $display("FAIL contention_%0d: got gnt=%b ack=%b at=%0d gap=%0d want %b/%b/1/%0d",
                                        n, o_g, o_ack, o_pk, o_wait, onehot(w), onehot(w), (n == 0) ? 1 : 2);
            end
        end
        bif.reqREQ = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        logic [NR-1:0] pulses;
        bif.reqREQ = 4'b0010;
        seen = 1'b0;
        for (int w = 0; w < 20 && !seen; w++) begin
            @(negedge clk);
            seen = bif.busREQO;
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL rstwait_req: got no busREQO want busREQO"); end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        bif.reqREQ = '0;
        @(negedge clk);
        rst = 1'b0;
        mptr = 0;
        vectors++;
        if ({bif.arbGNT, bif.arbACK, bif.arbNXM, bif.arbDATA, bif.arbBUSY,
             bif.busREQO, bif.busADDRO, bif.busDATAO} !== '0) begin
            miscompares++; $display("FAIL rstwait_outputs: got gnt=%b busy=%b breq=%b want all 0",
                                    bif.arbGNT, bif.arbBUSY, bif.busREQO);
        end
        pulses = '0;
        repeat (70) begin
            @(negedge clk);
            pulses = pulses | bif.arbACK | bif.arbNXM;
        end
        vectors++;
        if (pulses !== '0 || bif.arbBUSY !== 1'b0) begin
            miscompares++; $display("FAIL rstwait_silent: got pulses=%b busy=%b want 0000/0", pulses, bif.arbBUSY);
        end
        bif.reqREQ = 4'b1000;
        serve(2, 36'o246024602460, -1, '0);
        bif.reqREQ = '0;
        note_grant(3);
        vectors++;
        if (o_wait !== 1 || o_g !== 4'b1000 || o_pk !== 3 || o_ack !== 4'b1000 || o_dv !== 36'o246024602460) begin
            miscompares++; $display("FAIL rstwait_after: got gap=%0d gnt=%b at=%0d ack=%b want 1/1000/3/1000",
                                    o_wait, o_g, o_pk, o_ack);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_drop_req();
        bif.reqREQ = 4'b0100;
        // Requester 2 drops and requester 3 arrives in the first WAIT cycle.
        serve(3, 36'o101010101010, 1, 4'b1000);
        note_grant(2);
        vectors++;
        if (o_g !== 4'b0100 || o_pk !== 4 || o_ack !== 4'b0100 || o_nxm !== '0) begin
            miscompares++; $display("FAIL drop_ack: got gnt=%b at=%0d ack=%b nxm=%b want 0100/4/0100/0000",
                                    o_g, o_pk, o_ack, o_nxm);
        end
        serve(1, 36'o7, -1, '0);
        bif.reqREQ = '0;
        note_grant(3);
        vectors++;
        if (o_wait !== 2 || o_g !== 4'b1000 || o_ack !== 4'b1000) begin
            miscompares++; $display("FAIL drop_next: got gap=%0d gnt=%b ack=%b want 2/1000/1000", o_wait, o_g, o_ack);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [NR-1:0] pending;
        logic [35:0]   rd, exp_dv;
        int            w, lat;
        for (int i = 0; i < NR; i++) begin
            addr_tab[i] = {$urandom, $urandom} & 36'hF_FFFF_FFFF;
            data_tab[i] = {$urandom, $urandom} & 36'hF_FFFF_FFFF;
        end
        load_tables();
        pending = NR'($urandom_range(1, (1 << NR) - 1));
        bif.reqREQ = pending;
        for (int n = 0; n < 30; n++) begin
            w   = pick(pending, mptr);
            lat = ($urandom_range(0, 7) == 0) ? TO + 1 + int'($urandom_range(0, 3))
                                                : int'($urandom_range(0, 5));
            if (n == 5) lat = TO;  // ACK on the final watchdog cycle still wins
            rd  = {$urandom, $urandom} & 36'hF_FFFF_FFFF;
            serve(lat, rd, -1, '0);
            note_grant(w);
            exp_dv = (lat <= TO) ? rd : '0;
            vectors++;
            if (o_g !== onehot(w) || o_a !== addr_tab[w] || o_wd !== data_tab[w]) begin
                miscompares++; $display("FAIL b2b_%0d_grant: got gnt=%b addr=%h data=%h want %b/%h/%h",
                                        n, o_g, o_a, o_wd, onehot(w), addr_tab[w], data_tab[w]);
            end
            vectors++;
            if (o_wait !== ((n == 0) ? 1 : 2) || o_pk !== exp_pk(lat) || o_glen !== exp_pk(lat) || o_blen !== 1) begin
                miscompares++; $display("FAIL b2b_%0d_timing: got gap=%0d at=%0d gntlen=%0d breq=%0d want %0d/%0d/%0d/1",
                                        n, o_wait, o_pk, o_glen, o_blen, (n == 0) ? 1 : 2, exp_pk(lat), exp_pk(lat));
            end
            vectors++;
            if (o_ack !== ((lat <= TO) ? onehot(w) : '0) || o_nxm !== ((lat > TO) ? onehot(w) : '0) || o_dv !== exp_dv) begin
                miscompares++; $display("FAIL b2b_%0d_result: got ack=%b nxm=%b data=%h want lat=%0d winner=%0d data=%h",
                                        n, o_ack, o_nxm, o_dv, lat, w, exp_dv);
            end
            pending = (pending & ~onehot(w)) | NR'($urandom_range(0, (1 << NR) - 1));
            if (pending == '0) pending = onehot(int'($urandom_range(0, NR - 1)));
            bif.reqREQ = pending;
        end
        bif.reqREQ = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion within time limit want run to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_zero_wait();
        test_timeout();
        test_contention();
        test_reset_mid_wait();
        test_drop_req();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
